alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opcode  input  6  operation select, encodings per REQ-010.
REQ-004 r2  input  19  operand A.
REQ-005 r3  input  19  operand B.
REQ-006 imm  input  3  unsigned immediate, shift amount or add constant.
REQ-007 aluen  input  1  enable; operation executes only on an edge where aluen=1.
REQ-008 r1  output  19  registered result.
REQ-009 FLAG  output  8  registered status: [0] zero, [1] carry/borrow, [2] negative (r1[18]), [3] signed overflow, [4] divide-by-zero, [5] reserved 0, [6] invalid opcode, [7] reserved 0.

Function
REQ-010 Opcodes SHALL be: 000001 ADD r2+r3; 000010 SUB r2-r3; 000011 MUL r2*r3; 000100 DIV r2/r3; 000101 SHL r2<<imm; 000110 SHR r2>>imm (logical); 000111 AND; 001000 OR; 001001 XOR; 001010 NAND; 001011 NOT r2; 001100 ADDI r2+zero-extended imm.
REQ-011 On a rising edge with reset=0 and aluen=1, r1 and FLAG SHALL load the result of the current inputs; latency is exactly one cycle.
REQ-012 With aluen=0, r1 and FLAG SHALL hold their previous values.
REQ-013 Result is computed combinationally from the inputs present at the edge; inputs may change every cycle with no handshake.
REQ-014 ADD/ADDI: 20-bit unsigned sum; r1 = low 19 bits; FLAG[1] = bit 19; FLAG[3] = two's-complement overflow (same-sign operands, differing result sign).
REQ-015 SUB: r1 = (r2-r3) mod 2^19; FLAG[1] = 1 when r3 > r2 unsigned (borrow); FLAG[3] = signed overflow.
REQ-016 MUL: unsigned 38-bit product; r1 = low 19 bits; FLAG[1] and FLAG[3] = 1 when upper 19 bits are nonzero.
REQ-017 DIV: unsigned quotient, remainder discarded; r3=0 gives r1=0 and FLAG[4]=1.
REQ-018 SHL/SHR: FLAG[1] = last bit shifted out (0 when imm=0); FLAG[3]=0.
REQ-019 Logic ops (AND, OR, XOR, NAND, NOT): FLAG[1]=FLAG[3]=0; r3 ignored by NOT.
REQ-020 FLAG[0] = (r1 result == 0); FLAG[2] = r1 result bit 18, for every executed opcode including invalid.
REQ-021 Unlisted opcode with aluen=1: r1=0, FLAG[6]=1, FLAG[0]=1, other flag bits 0.
REQ-022 Flags not defined for an operation SHALL be 0; FLAG[5] and FLAG[7] are always 0.

Reset
REQ-023 reset=1 at a rising edge SHALL set r1=0 and FLAG=0, overriding aluen.
REQ-024 Reset mid-sequence discards the pending operation; the next enabled edge after deassertion executes normally.

Structure
REQ-025 Opcode encodings and FLAG bit indices SHALL be constants in a shared package (alu_pkg).
REQ-026 Single module; combinational result/flag logic plus one output register stage; no sub-module required.

Verification
REQ-027 ADD r2=10, r3=15, aluen=1 -> next cycle r1=25, FLAG=00000000.
REQ-028 SUB 20-5 -> r1=15, FLAG=0; MUL 3*4 -> r1=12, FLAG=0; DIV 40/8 -> r1=5, FLAG=0.
REQ-029 DIV r2=10, r3=0 -> r1=0, FLAG=00010001.
REQ-030 AND r2=1010101010101010101, r3=1100110011001100110 -> r1=1000100010001000100, FLAG=00000100; NOT same r2 -> r1=0101010101010101010, FLAG=0.
REQ-031 opcode=111111 -> r1=0, FLAG=01000001; then aluen=0 with changing inputs -> r1/FLAG unchanged.
REQ-032 ADD 0x7FFFF+1 -> r1=0, FLAG=00000011; reset asserted mid-stream -> r1=0, FLAG=0 next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU: opcode encodings, FLAG bit positions and datapath widths.
package alu_pkg;

    localparam int DATA_W = 19;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 3;
    localparam int FLAG_W = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 6'b000001;
    localparam logic [OP_W-1:0] OP_SUB  = 6'b000010;
    localparam logic [OP_W-1:0] OP_MUL  = 6'b000011;
    localparam logic [OP_W-1:0] OP_DIV  = 6'b000100;
    localparam logic [OP_W-1:0] OP_SHL  = 6'b000101;
    localparam logic [OP_W-1:0] OP_SHR  = 6'b000110;
    localparam logic [OP_W-1:0] OP_AND  = 6'b000111;
    localparam logic [OP_W-1:0] OP_OR   = 6'b001000;
    localparam logic [OP_W-1:0] OP_XOR  = 6'b001001;
    localparam logic [OP_W-1:0] OP_NAND = 6'b001010;
    localparam logic [OP_W-1:0] OP_NOT  = 6'b001011;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001100;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_DIVZ  = 4;
    localparam int FLAG_INV   = 6;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: combinational result/flag logic feeding one registered output stage.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] r2,
    input  logic [DATA_W-1:0] r3,
    input  logic [IMM_W-1:0]  imm,
    input  logic              aluen,
    output logic [DATA_W-1:0] r1,
    output logic [FLAG_W-1:0] FLAG
);

    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     shl;
    logic [DATA_W:0]     shr;
    logic [DATA_W-1:0]   res;
    logic                carry;
    logic                ovf;
    logic                divz;
    logic                inv;
    logic [FLAG_W-1:0]   flag_next;

    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};

    always_comb begin
        sum   = '0;
        diff  = '0;
        prod  = '0;
        shl   = '0;
        shr   = '0;
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        divz  = 1'b0;
        inv   = 1'b0;
        case (opcode)
            OP_ADD: begin
                sum   = {1'b0, r2} + {1'b0, r3};
                res   = sum[DATA_W-1:0];
                carry = sum[DATA_W];
                ovf   = (r2[DATA_W-1] == r3[DATA_W-1]) && (res[DATA_W-1] != r2[DATA_W-1]);
            end
            OP_ADDI: begin
                sum   = {1'b0, r2} + {1'b0, imm_ext};
                res   = sum[DATA_W-1:0];
                carry = sum[DATA_W];
                ovf   = (r2[DATA_W-1] == imm_ext[DATA_W-1]) && (res[DATA_W-1] != r2[DATA_W-1]);
            end
            OP_SUB: begin
                diff  = {1'b0, r2} - {1'b0, r3};
                res   = diff[DATA_W-1:0];
                carry = (r3 > r2);
                ovf   = (r2[DATA_W-1] != r3[DATA_W-1]) && (res[DATA_W-1] != r2[DATA_W-1]);
            end
            OP_MUL: begin
                prod  = {{DATA_W{1'b0}}, r2} * {{DATA_W{1'b0}}, r3};
                res   = prod[DATA_W-1:0];
                carry = |prod[2*DATA_W-1:DATA_W];
                ovf   = |prod[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                if (r3 == '0) begin
                    divz = 1'b1;
                end else begin
                    res = r2 / r3;
                end
            end
            // The extra bit beyond either end of the operand catches the last bit shifted out.
            OP_SHL: begin
                shl   = {1'b0, r2} << imm;
                res   = shl[DATA_W-1:0];
                carry = shl[DATA_W];
            end
            OP_SHR: begin
                shr   = {r2, 1'b0} >> imm;
                res   = shr[DATA_W:1];
                carry = shr[0];
            end
            OP_AND:  res = r2 & r3;
            OP_OR:   res = r2 | r3;
            OP_XOR:  res = r2 ^ r3;
            OP_NAND: res = ~(r2 & r3);
            OP_NOT:  res = ~r2;
            default: inv = 1'b1;
        endcase
    end

    always_comb begin
        flag_next             = '0;
        flag_next[FLAG_ZERO]  = (res == '0);
        flag_next[FLAG_CARRY] = carry;
        flag_next[FLAG_NEG]   = res[DATA_W-1];
        flag_next[FLAG_OVF]   = ovf;
        flag_next[FLAG_DIVZ]  = divz;
        flag_next[FLAG_INV]   = inv;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1   <= '0;
            FLAG <= '0;
        end else if (aluen) begin
            r1   <= res;
            FLAG <= flag_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: each step drives one operation and checks r1/FLAG one cycle later.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [18:0] r2;
    logic [18:0] r3;
    logic [2:0]  imm;
    logic        aluen;
    logic [18:0] r1;
    logic [7:0]  FLAG;

    int checks = 0;
    int passed = 0;

    alu dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .r2     (r2),
        .r3     (r3),
        .imm    (imm),
        .aluen  (aluen),
        .r1     (r1),
        .FLAG   (FLAG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [18:0] exp_r1, input logic [7:0] exp_flag);
        checks++;
        assert (r1 === exp_r1) passed++;
        else $error("FAIL %s r1: got %h expected %h", tag, r1, exp_r1);
        checks++;
        assert (FLAG === exp_flag) passed++;
        else $error("FAIL %s FLAG: got %b expected %b", tag, FLAG, exp_flag);
    endtask

    // Drive one operation, let one rising edge capture it, then sample 1 time unit later.
    task automatic step(input logic [5:0] op, input logic [18:0] a, input logic [18:0] b,
                        input logic [2:0] im, input logic en, input logic rst);
        opcode = op;
        r2     = a;
        r3     = b;
        imm    = im;
        aluen  = en;
        reset  = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; aluen = 1'b0; opcode = '0; r2 = '0; r3 = '0; imm = '0;
        @(posedge clk);
        #1;

        step(6'b000001, 19'd10, 19'd15, 3'd0, 1'b1, 1'b1);
        check("reset_overrides_en", 19'd0, 8'h00);

        step(6'b000001, 19'd10, 19'd15, 3'd0, 1'b1, 1'b0);
        check("add_10_15", 19'd25, 8'h00);
        step(6'b000010, 19'd20, 19'd5, 3'd0, 1'b1, 1'b0);
        check("sub_20_5", 19'd15, 8'h00);
        step(6'b000011, 19'd3, 19'd4, 3'd0, 1'b1, 1'b0);
        check("mul_3_4", 19'd12, 8'h00);
        step(6'b000100, 19'd40, 19'd8, 3'd0, 1'b1, 1'b0);
        check("div_40_8", 19'd5, 8'h00);
        step(6'b000100, 19'd10, 19'd0, 3'd0, 1'b1, 1'b0);
        check("div_by_zero", 19'd0, 8'h11);

        step(6'b000111, 19'b1010101010101010101, 19'b1100110011001100110, 3'd0, 1'b1, 1'b0);
        check("and", 19'b1000100010001000100, 8'h04);
        step(6'b001011, 19'b1010101010101010101, 19'h7ffff, 3'd0, 1'b1, 1'b0);
        check("not", 19'b0101010101010101010, 8'h00);

        step(6'b111111, 19'd123, 19'd45, 3'd5, 1'b1, 1'b0);
        check("invalid_3f", 19'd0, 8'h41);
        step(6'b000001, 19'd7, 19'd9, 3'd1, 1'b0, 1'b0);
        check("hold_1", 19'd0, 8'h41);
        step(6'b000011, 19'h12345, 19'h54321, 3'd6, 1'b0, 1'b0);
        check("hold_2", 19'd0, 8'h41);

        step(6'b000001, 19'h7ffff, 19'd1, 3'd0, 1'b1, 1'b0);
        check("add_wrap_carry", 19'd0, 8'h03);
        step(6'b000001, 19'h3ffff, 19'd1, 3'd0, 1'b1, 1'b0);
        check("add_signed_ovf", 19'h40000, 8'h0c);
        step(6'b000010, 19'd5, 19'd20, 3'd0, 1'b1, 1'b0);
        check("sub_borrow", 19'h7fff1, 8'h06);
        step(6'b000010, 19'h40000, 19'd1, 3'd0, 1'b1, 1'b0);
        check("sub_signed_ovf", 19'h3ffff, 8'h08);
        step(6'b000011, 19'h40000, 19'd4, 3'd0, 1'b1, 1'b0);
        check("mul_high_bits", 19'd0, 8'h0b);

        step(6'b000101, 19'h40001, 19'd0, 3'd1, 1'b1, 1'b0);
        check("shl_carry_out", 19'h00002, 8'h06 & 8'h02);
        step(6'b000101, 19'd5, 19'd0, 3'd0, 1'b1, 1'b0);
        check("shl_by_zero", 19'd5, 8'h00);
        step(6'b000110, 19'd3, 19'd0, 3'd2, 1'b1, 1'b0);
        check("shr_to_zero", 19'd0, 8'h03);
        step(6'b000110, 19'h40000, 19'd0, 3'd7, 1'b1, 1'b0);
        check("shr_by_7", 19'h00800, 8'h00);

        step(6'b001100, 19'h7ffff, 19'd0, 3'd7, 1'b1, 1'b0);
        check("addi_carry", 19'd6, 8'h02);
        step(6'b001000, 19'h000f0, 19'h0000f, 3'd0, 1'b1, 1'b0);
        check("or", 19'h000ff, 8'h00);
        step(6'b001001, 19'h7ffff, 19'h7ffff, 3'd0, 1'b1, 1'b0);
        check("xor_zero", 19'd0, 8'h01);
        step(6'b001010, 19'd0, 19'd0, 3'd0, 1'b1, 1'b0);
        check("nand_all_ones", 19'h7ffff, 8'h04);
        step(6'b000000, 19'd1, 19'd1, 3'd0, 1'b1, 1'b0);
        check("invalid_00", 19'd0, 8'h41);

        step(6'b000001, 19'd100, 19'd200, 3'd0, 1'b1, 1'b0);
        check("add_before_reset", 19'd300, 8'h00);
        step(6'b000011, 19'd100, 19'd200, 3'd0, 1'b1, 1'b1);
        check("reset_mid_stream", 19'd0, 8'h00);
        step(6'b000001, 19'd10, 19'd15, 3'd0, 1'b1, 1'b0);
        check("add_after_reset", 19'd25, 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
